muldiv_div: RTL

MULDIV_DIV -- requirements
Module: muldiv_div

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_div_step.sv | 29 ++
 rtl/muldiv_div.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the MUL/DIV unit: default datapath width and divider FSM encoding.
package muldiv_pkg;

  localparam int unsigned MulDivWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

  // Iteration counter width: clog2(width) + 1 so that width itself is representable.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring radix-2 division iteration: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference and set the quotient LSB only when it is non-negative.
module muldiv_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit so the borrow of the trial subtraction shows up as diff[WIDTH].
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_i};

  always_comb begin
    rem_o = shifted[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: owns the FSM, iteration counter,
// operand magnitude/sign capture and the final sign correction.
module muldiv_div
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MulDivWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_abort,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_rdy,
  output logic             div_busy
);

  localparam int unsigned CntW = div_cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             hold_q, hold_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign dvd_neg = op_signed & dividend[WIDTH-1];
  assign dvs_neg = op_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  muldiv_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    hold_d      = hold_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    unique case (state_q)
      StIdle: begin
        if (!div_start) begin
          hold_d = 1'b0;
        end
        // hold_q blocks a relaunch while start is still high from the previous request.
        if (div_start && !div_abort && !hold_q) begin
          state_d   = StCalc;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = dvd_mag;
          dvs_d     = dvs_mag;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          dz_d      = (divisor == '0);
        end
      end
      StCalc: begin
        if (div_abort) begin
          state_d = StIdle;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        if (div_abort) begin
          state_d = StIdle;
        end else begin
          // A zero divisor leaves rem = |dividend|, so the remainder fix restores the raw value.
          quotient_d  = dz_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
          remainder_d = neg_rem_q ? -rem_q : rem_q;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        hold_d  = div_start & ~div_abort;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      hold_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      hold_q      <= hold_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  // An abort arriving in DONE cancels the pulse as well.
  assign div_rdy   = (state_q == StDone) && !div_abort;
  assign div_busy  = (state_q != StIdle);

endmodule
